// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared definitions for the unified-memory arbiter
// Purpose: FSM state encodings, grant ids and the wait-counter width helper
//          used by mem_arbiter and wait_counter.
// Ports:   none (package).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic GNT_CORE = 1'b0;
  localparam logic GNT_EXT  = 1'b1;

  // Counter must be able to hold the value WAIT_CYCLES itself.
  function automatic int cnt_width(input int wait_cycles);
    return $clog2(wait_cycles + 1);
  endfunction

endpackage

// File: rtl/wait_counter.sv
// rtl/wait_counter.sv - loadable down-counter timing a memory access
// Purpose: loaded with WAIT_CYCLES when an access is granted, counts down
//          while the access is in progress; last flags the final cycle.
// Ports:   clk   - clock, rising edge
//          rst   - asynchronous active-high reset (count -> 0)
//          load  - load WAIT_CYCLES
//          en    - decrement by one
//          last  - count == 1
module wait_counter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic last
);
  import mem_arb_pkg::*;

  localparam int CNT_W = cnt_width(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign last = (count == CNT_W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - core / loader arbiter for the single-port unified memory
// Purpose: serialises core and external (loader/debug) accesses to the memory
//          macro, holds each access for WAIT_CYCLES cycles and returns a
//          one-cycle ack with read data.
//          Build option MEM_ARB_FAIR_EN: round-robin on ties (core wins the
//          first tie after reset); undefined: core always wins ties.
// Ports:   clk, rst                          - clock, async active-high reset
//          core_req/we/addr/wdata, core_ack/rdata - core requester
//          ext_req/we/addr/wdata,  ext_ack/rdata  - loader/debug requester
//          mem_en/we/addr/wdata, mem_rdata   - memory macro
//          grant_ext                         - external port owns the memory
module mem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_ack,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_ack,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              grant_ext
);
  import mem_arb_pkg::*;

  generate
    if (WAIT_CYCLES < 1) begin : g_bad_wait
      $error("mem_arbiter: WAIT_CYCLES must be at least 1");
    end
  endgenerate

  state_t            state;
  logic              win_ext;
  logic              any_req;
  logic              cnt_load;
  logic              cnt_last;
  logic [DATA_W-1:0] rdata_q;
`ifdef MEM_ARB_FAIR_EN
  logic              last_grant;
`endif

  assign any_req = core_req | ext_req;

  // Winner of the current IDLE arbitration round.
  always_comb begin
    win_ext = GNT_CORE;
    if (ext_req && !core_req) begin
      win_ext = GNT_EXT;
`ifdef MEM_ARB_FAIR_EN
    end else if (ext_req && core_req && (last_grant == GNT_CORE)) begin
      win_ext = GNT_EXT;
`endif
    end
  end

  assign cnt_load = (state == ST_IDLE) && any_req;

  wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_counter (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .en   (state == ST_ACCESS),
    .last (cnt_last)
  );

  // Both requesters see the one shared read-data register.
  assign core_rdata = rdata_q;
  assign ext_rdata  = rdata_q;

  // grant_ext doubles as the latched winner id for the whole transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rdata_q    <= '0;
      core_ack   <= 1'b0;
      ext_ack    <= 1'b0;
      grant_ext  <= 1'b0;
`ifdef MEM_ARB_FAIR_EN
      last_grant <= GNT_EXT;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            state      <= ST_ACCESS;
            mem_en     <= 1'b1;
            grant_ext  <= win_ext;
            mem_we     <= win_ext ? ext_we    : core_we;
            mem_addr   <= win_ext ? ext_addr  : core_addr;
            mem_wdata  <= win_ext ? ext_wdata : core_wdata;
`ifdef MEM_ARB_FAIR_EN
            last_grant <= win_ext;
`endif
          end
        end
        ST_ACCESS: begin
          if (cnt_last) begin
            if (!mem_we) begin
              rdata_q <= mem_rdata;
            end
            state    <= ST_RESP;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            core_ack <= (grant_ext == GNT_CORE);
            ext_ack  <= (grant_ext == GNT_EXT);
          end
        end
        ST_RESP: begin
          state     <= ST_IDLE;
          core_ack  <= 1'b0;
          ext_ack   <= 1'b0;
          grant_ext <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
// Purpose: drives two arbiters (WAIT_CYCLES 1 and 3) against a bench memory
//          that only returns valid data in the last access cycle, and checks
//          them against a transaction-level reference model.
// Ports:   none (top-level bench).
module tb_mem_arbiter;

`ifdef MEM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst        [2];
  logic        core_req   [2];
  logic        core_we    [2];
  logic [15:0] core_addr  [2];
  logic [15:0] core_wdata [2];
  logic        core_ack   [2];
  logic [15:0] core_rdata [2];
  logic        ext_req    [2];
  logic        ext_we     [2];
  logic [15:0] ext_addr   [2];
  logic [15:0] ext_wdata  [2];
  logic        ext_ack    [2];
  logic [15:0] ext_rdata  [2];
  logic        mem_en     [2];
  logic        mem_we     [2];
  logic [15:0] mem_addr   [2];
  logic [15:0] mem_wdata  [2];
  logic [15:0] mem_rdata  [2];
  logic        grant_ext  [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(1)) dut_w1 (
    .clk(clk), .rst(rst[0]),
    .core_req(core_req[0]), .core_we(core_we[0]), .core_addr(core_addr[0]),
    .core_wdata(core_wdata[0]), .core_ack(core_ack[0]), .core_rdata(core_rdata[0]),
    .ext_req(ext_req[0]), .ext_we(ext_we[0]), .ext_addr(ext_addr[0]),
    .ext_wdata(ext_wdata[0]), .ext_ack(ext_ack[0]), .ext_rdata(ext_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .grant_ext(grant_ext[0])
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(3)) dut_w3 (
    .clk(clk), .rst(rst[1]),
    .core_req(core_req[1]), .core_we(core_we[1]), .core_addr(core_addr[1]),
    .core_wdata(core_wdata[1]), .core_ack(core_ack[1]), .core_rdata(core_rdata[1]),
    .ext_req(ext_req[1]), .ext_we(ext_we[1]), .ext_addr(ext_addr[1]),
    .ext_wdata(ext_wdata[1]), .ext_ack(ext_ack[1]), .ext_rdata(ext_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .grant_ext(grant_ext[1])
  );

  function automatic int wc(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Power-on memory contents; address 0x10 holds 16'hA5C3.
  function automatic logic [15:0] init_pat(input logic [7:0] a);
    return {a, ~a} ^ 16'hB52C;
  endfunction

  // Bench memory: data is only valid in the WAIT_CYCLES-th enable cycle.
  int          en_cnt   [2];
  bit   [15:0] resp_mem [2][256];
  bit          resp_wr  [2][256];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_en[i]) begin
        if (mem_we[i] && (en_cnt[i] == wc(i) - 1)) begin
          resp_mem[i][mem_addr[i][7:0]] <= mem_wdata[i];
          resp_wr[i][mem_addr[i][7:0]]  <= 1'b1;
        end
        en_cnt[i] <= en_cnt[i] + 1;
      end else begin
        en_cnt[i] <= 0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      mem_rdata[i] = 16'hDEAD;
      if (mem_en[i] && !mem_we[i] && (en_cnt[i] == wc(i) - 1)) begin
        mem_rdata[i] = resp_wr[i][mem_addr[i][7:0]] ? resp_mem[i][mem_addr[i][7:0]]
                                                     : init_pat(mem_addr[i][7:0]);
      end
    end
  end

  // Reference model state.
  logic [15:0] exp_mem  [2][256];
  bit          last_win [2];
  logic [15:0] rd_model [2];

  task automatic chk(input int i, input string name, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL d%0d_%s: got %0h expected %0h", i, name, obs, exp);
    end
  endtask

  // One arbitration round, called at a negedge in an IDLE cycle.
  task automatic round(input int i,
                       input bit creq, input bit cwe, input logic [15:0] caddr,
                       input logic [15:0] cwdata,
                       input bit ereq, input bit ewe, input logic [15:0] eaddr,
                       input logic [15:0] ewdata,
                       input bit hold, input bit drop_mid, output bit got_ext);
    bit          wx;
    bit          w;
    logic [15:0] a;
    logic [15:0] d;
    int          n;
    core_req[i] = creq; core_we[i] = cwe; core_addr[i] = caddr; core_wdata[i] = cwdata;
    ext_req[i]  = ereq; ext_we[i]  = ewe; ext_addr[i]  = eaddr; ext_wdata[i]  = ewdata;
    chk(i, "idle_mem_en", mem_en[i], 0);
    chk(i, "idle_core_ack", core_ack[i], 0);
    chk(i, "idle_ext_ack", ext_ack[i], 0);
    chk(i, "idle_grant_ext", grant_ext[i], 0);
    if (creq && ereq) wx = FAIR ? !last_win[i] : 1'b0;
    else              wx = ereq;
    last_win[i] = wx;
    w = wx ? ewe : cwe;
    a = wx ? eaddr : caddr;
    d = wx ? ewdata : cwdata;
    n = wc(i);
    got_ext = 1'b0;
    for (int c = 1; c <= n + 1; c++) begin
      @(negedge clk);
      if (drop_mid && c == 1) begin
        core_req[i] = 1'b0;
        ext_req[i]  = 1'b0;
      end
      if (c <= n) begin
        chk(i, "acc_mem_en", mem_en[i], 1);
        chk(i, "acc_mem_we", mem_we[i], w);
        chk(i, "acc_mem_addr", mem_addr[i], a);
        if (w) chk(i, "acc_mem_wdata", mem_wdata[i], d);
        chk(i, "acc_core_ack", core_ack[i], 0);
        chk(i, "acc_ext_ack", ext_ack[i], 0);
        chk(i, "acc_grant_ext", grant_ext[i], wx);
      end else begin
        if (w) exp_mem[i][a[7:0]] = d;
        else   rd_model[i] = exp_mem[i][a[7:0]];
        got_ext = ext_ack[i];
        chk(i, "resp_mem_en", mem_en[i], 0);
        chk(i, "resp_core_ack", core_ack[i], !wx);
        chk(i, "resp_ext_ack", ext_ack[i], wx);
        chk(i, "resp_grant_ext", grant_ext[i], wx);
        chk(i, "resp_core_rdata", core_rdata[i], rd_model[i]);
        chk(i, "resp_ext_rdata", ext_rdata[i], rd_model[i]);
      end
    end
    if (!hold) begin
      core_req[i] = 1'b0;
      ext_req[i]  = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic check_reset_values(input int i);
    chk(i, "rst_mem_en", mem_en[i], 0);
    chk(i, "rst_mem_we", mem_we[i], 0);
    chk(i, "rst_core_ack", core_ack[i], 0);
    chk(i, "rst_ext_ack", ext_ack[i], 0);
    chk(i, "rst_grant_ext", grant_ext[i], 0);
    chk(i, "rst_mem_addr", mem_addr[i], 0);
    chk(i, "rst_mem_wdata", mem_wdata[i], 0);
    chk(i, "rst_core_rdata", core_rdata[i], 0);
    chk(i, "rst_ext_rdata", ext_rdata[i], 0);
  endtask

  task automatic reset_mid(input int i);
    bit g;
    core_req[i] = 1'b1; core_we[i] = 1'b0; core_addr[i] = 16'h0020; core_wdata[i] = 16'h0;
    @(negedge clk);
    chk(i, "rmid_mem_en", mem_en[i], 1);
    rst[i] = 1'b1;
    #1;
    check_reset_values(i);
    last_win[i] = 1'b1;
    rd_model[i] = 16'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk(i, "rmid_no_core_ack", core_ack[i], 0);
      chk(i, "rmid_no_mem_en", mem_en[i], 0);
    end
    rst[i] = 1'b0;
    round(i, 1'b1, 1'b0, 16'h0020, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, g);
    chk(i, "rmid_served", g, 0);
  endtask

  task automatic tie_test(input int i);
    bit       g;
    bit [3:0] seq;
    rst[i] = 1'b1;
    @(negedge clk);
    rst[i] = 1'b0;
    last_win[i] = 1'b1;
    rd_model[i] = 16'h0;
    for (int k = 0; k < 4; k++) begin
      round(i, 1'b1, 1'b0, 16'(16'h0030 + k), 16'h0, 1'b1, 1'b0, 16'(16'h0040 + k), 16'h0,
            (k != 3), 1'b0, g);
      seq[k] = g;
    end
    chk(i, "tie_grant_seq", seq, FAIR ? 4'b1010 : 4'b0000);
  endtask

  initial begin
    bit g;
    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < 256; a++) exp_mem[i][a] = init_pat(8'(a));
      rst[i] = 1'b1;
      core_req[i] = 1'b0; core_we[i] = 1'b0; core_addr[i] = 16'h0; core_wdata[i] = 16'h0;
      ext_req[i]  = 1'b0; ext_we[i]  = 1'b0; ext_addr[i]  = 16'h0; ext_wdata[i]  = 16'h0;
      last_win[i] = 1'b1;
      rd_model[i] = 16'h0;
    end
    @(negedge clk);
    @(negedge clk);
    check_reset_values(0);
    check_reset_values(1);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);

    // Core read of 0x0010, then ext write of 0x1234 to 0x0100.
    round(0, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, g);
    chk(0, "core_read_data", core_rdata[0], 16'hA5C3);
    round(0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h0100, 16'h1234, 1'b0, 1'b0, g);
    chk(0, "ext_write_ack", g, 1);
    chk(0, "ext_write_keeps_rdata", core_rdata[0], 16'hA5C3);

    // Three-cycle latency read.
    round(1, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, g);
    chk(1, "core_read_data", core_rdata[1], 16'hA5C3);

    // Requester abandons req mid-access.
    round(0, 1'b1, 1'b0, 16'h0005, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, g);
    round(1, 1'b1, 1'b0, 16'h0005, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, g);

    reset_mid(0);
    reset_mid(1);
    tie_test(0);
    tie_test(1);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 30; k++) begin
        bit cr;
        bit er;
        cr = 1'($urandom_range(0, 1));
        er = 1'($urandom_range(0, 1));
        if (!cr && !er) cr = 1'b1;
        round(i, cr, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 16'($urandom),
              er, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 16'($urandom),
              1'b0, 1'b0, g);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
